// File: rtl/ifetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_ctrl_pkg
//  Description : Shared types and constants for the instruction-fetch block.
//                Holds the sequencer state enum, the buffered fetch entry
//                and the instruction size in bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifetch_ctrl_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } ifetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_fifo2
//  Description : Two-entry FIFO of {pc, instr} between fetch and decode.
//                Push and pop may happen together at any occupancy; flush
//                empties the buffer and wins over push/pop in that cycle.
//                The head entry is presented straight from storage.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fifo2
    import ifetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output fetch_entry_t rd_data,
    output logic [1:0]   count
);

    fetch_entry_t r_mem [0:1];
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic         w_pop_en;
    logic         w_wr_ptr;

    // A pop of an empty buffer is meaningless, so it is dropped here.
    assign w_pop_en = pop & (r_count != 2'd0);
    // Write slot sits count entries past the head; with count 2 and a
    // simultaneous pop that is the slot the head is vacating.
    assign w_wr_ptr = r_rd_ptr ^ r_count[0];

    // Storage, head pointer and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[w_wr_ptr] <= wr_data;
            end
            if (w_pop_en) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, w_pop_en})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_ctrl
//  Description : Instruction-fetch sequencer. Owns the PC, addresses the
//                combinational instruction memory, buffers fetched words in
//                a 2-entry FIFO towards decode and handles PC redirects
//                (with wrong-path flush) from execute.
//                Optional bounds check enabled by IFETCH_BOUNDS_CHECK_EN:
//                a PC at or beyond 4*IMEM_WORDS in RUN raises a sticky
//                fault and halts fetching.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_read,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic        busy
);

`ifdef IFETCH_BOUNDS_CHECK_EN
    localparam logic c_bounds_en = 1'b1;
`else
    localparam logic c_bounds_en = 1'b0;
`endif

    localparam logic [31:0] c_pc_limit  = 32'(INSTR_BYTES * IMEM_WORDS);
    localparam logic [31:0] c_pc_step   = 32'(INSTR_BYTES);
    localparam logic [31:0] c_align_msk = ~32'(INSTR_BYTES - 1);

    ifetch_state_e r_state;
    ifetch_state_e w_state_nxt;
    logic [31:0]   r_pc;
    logic          r_fault;

    logic          w_redirect_act;
    logic          w_oob;
    logic          w_pop;
    logic          w_push;
    logic [1:0]    w_count;
    fetch_entry_t  w_wr_entry;
    fetch_entry_t  w_head;

    // Redirect is ignored only once halted; it preempts push and bounds check.
    assign w_redirect_act = redirect & (r_state != ST_HALT);
    assign w_oob          = c_bounds_en & (r_state == ST_RUN) & ~redirect
                          & (r_pc >= c_pc_limit);
    assign w_pop          = out_valid & out_ready;
    assign w_push         = (r_state == ST_RUN) & ~redirect & ~w_oob
                          & ((w_count != 2'd2) | w_pop);

    assign w_wr_entry.pc    = r_pc;
    assign w_wr_entry.instr = imem_read;

    ifetch_fifo2 u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (w_redirect_act),
        .wr_data (w_wr_entry),
        .rd_data (w_head),
        .count   (w_count)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start leaves IDLE, a bounds fault ends RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_oob) w_state_nxt = ST_HALT;
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Program counter: redirect target (word aligned) or sequential advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (w_redirect_act) begin
            r_pc <= redirect_pc & c_align_msk;
        end else if (w_push) begin
            r_pc <= r_pc + c_pc_step;
        end
    end

    // Sticky bounds-violation flag; stays 0 when the check is not built in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_oob) begin
            r_fault <= 1'b1;
        end
    end

    assign imem_addr = r_pc;
    assign out_valid = (w_count != 2'd0);
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;
    assign fault     = r_fault;
    assign busy      = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_ctrl
//  Description : Self-checking bench for ifetch_ctrl. Directed scenarios
//                followed by randomized traffic, all compared against a
//                queue-based reference model of the fetch buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_ctrl;

`ifdef IFETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    localparam int MI = 0;
    localparam int MR = 1;
    localparam int MH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_read;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rom [0:19];
    ent_t        mq[$];
    logic [31:0] acc[$];
    logic [31:0] m_pc;
    int          m_state;
    logic        m_fault;

    always #5 clk = ~clk;

    ifetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (20)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_read   (imem_read),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .fault       (fault),
        .busy        (busy)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [29:0] idx;
        idx = a[31:2];
        if (idx < 30'd20) return rom[idx[4:0]];
        return {16'hA5A5, a[15:0]};
    endfunction

    always_comb imem_read = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference behaviour for one rising edge, from the current inputs.
    task automatic model_edge();
        bit pop;
        if (reset) begin
            mq.delete();
            m_pc    = 32'h0;
            m_state = MI;
            m_fault = 1'b0;
        end else begin
            pop = (mq.size() > 0) && out_ready;
            if (redirect && m_state != MH) begin
                mq.delete();
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                if (m_state == MI && start) m_state = MR;
            end else begin
                if (pop) begin
                    acc.push_back(mq[0].pc);
                    void'(mq.pop_front());
                end
                if (m_state == MR) begin
                    if (BOUNDS && m_pc >= 32'd80) begin
                        m_fault = 1'b1;
                        m_state = MH;
                    end else if (mq.size() < 2) begin
                        mq.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                        m_pc = m_pc + 32'd4;
                    end
                end else if (m_state == MI && start) begin
                    m_state = MR;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_instr", out_instr, mq[0].instr);
        end
        chk("imem_addr", imem_addr, m_pc);
        chk("busy", 32'(busy), 32'(m_state == MR));
        chk("fault", 32'(fault), 32'(m_fault));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; redirect = 1'b0; out_ready = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        acc.delete();
    endtask

    task automatic start_run(input logic rdy);
        start = 1'b1; out_ready = rdy;
        tick();
        start = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect = 1'b1; redirect_pc = target;
        tick();
        redirect = 1'b0;
    endtask

    initial begin
        int hits;
        bit found;
        for (int i = 0; i < 20; i++) rom[i] = 32'h1000_0000 + 32'(i);
        rom[0]  = 32'h8C01_0008;
        rom[1]  = 32'hAC01_0010;
        rom[2]  = 32'h8C20_0001;
        rom[8]  = 32'hFC00_0000;
        rom[12] = 32'h0C00_0013;
        rom[15] = 32'h3842_000A;
        rom[19] = 32'h20E0_0000;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Straight-line fetch
        start_run(1'b1);
        tick();
        chk("sl_pc0", out_pc, 32'h0);
        chk("sl_in0", out_instr, 32'h8C01_0008);
        tick();
        chk("sl_pc1", out_pc, 32'h4);
        chk("sl_in1", out_instr, 32'hAC01_0010);
        tick();
        chk("sl_pc2", out_pc, 32'h8);
        chk("sl_in2", out_instr, 32'h8C20_0001);

        // Backpressure
        do_reset();
        start_run(1'b0);
        repeat (4) tick();
        chk("bp_head", out_pc, 32'h0);
        chk("bp_addr", imem_addr, 32'h8);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("bp_nacc", 32'(acc.size()), 32'd3);
        if (acc.size() >= 3) begin
            chk("bp_acc0", acc[0], 32'h0);
            chk("bp_acc1", acc[1], 32'h4);
            chk("bp_acc2", acc[2], 32'h8);
        end

        // Redirect flush at the jal
        do_reset();
        start_run(1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (out_valid && out_pc == 32'h30) found = 1'b1;
        end
        chk("find_jal", 32'(found), 32'h1);
        redirect_to(32'h4C);
        chk("rd_gap", 32'(out_valid), 32'h0);
        tick();
        chk("rd_pc", out_pc, 32'h4C);
        chk("rd_instr", out_instr, 32'h20E0_0000);
        repeat (3) tick();
        hits = 0;
        foreach (acc[i]) if (acc[i] == 32'h34) hits++;
        chk("no_wrong_path", 32'(hits), 32'h0);

        // Redirect alignment
        do_reset();
        start_run(1'b1);
        tick();
        redirect_to(32'h3F);
        tick();
        chk("al_pc", out_pc, 32'h3C);
        chk("al_instr", out_instr, 32'h3842_000A);

        // Bounds behaviour
        do_reset();
        start_run(1'b1);
        redirect_to(32'h4C);
        tick();
        chk("bd_pc4c", out_pc, 32'h4C);
        tick();
`ifdef IFETCH_BOUNDS_CHECK_EN
        chk("bd_fault", 32'(fault), 32'h1);
        chk("bd_busy", 32'(busy), 32'h0);
        hits = 0;
        foreach (acc[i]) if (acc[i] == 32'h4C) hits++;
        chk("bd_drain", 32'(hits), 32'h1);
        repeat (2) tick();
        chk("bd_addr", imem_addr, 32'h50);
`else
        chk("bd_pc50", out_pc, 32'h50);
        tick();
        chk("bd_pc54", out_pc, 32'h54);
        chk("bd_nofault", 32'(fault), 32'h0);
`endif

        // Reset mid-run with a full buffer
        do_reset();
        start_run(1'b0);
        redirect_to(32'h08);
        repeat (2) tick();
        chk("mr_addr", imem_addr, 32'h10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_valid", 32'(out_valid), 32'h0);
        chk("mr_addr0", imem_addr, 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        repeat (3) tick();
        chk("mr_idle", imem_addr, 32'h0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            reset       = ($urandom_range(0, 99) < 2);
            start       = ($urandom_range(0, 99) < 15);
            out_ready   = ($urandom_range(0, 99) < 60);
            redirect    = ($urandom_range(0, 99) < 8);
            redirect_pc = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h7F));
            tick();
        end
        reset = 1'b0; start = 1'b0; redirect = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
